mc_control: RTL
===============

Name: mc_control

Overview:
Main control FSM for the multi-cycle MIPS datapath. It sequences fetch, decode, execute, memory and writeback for each instruction. It drives all datapath enables and mux selects, including the 2-bit alu_op consumed by the ALU control decoder. It sits between the instruction register (opcode/funct) and the datapath, and paces memory accesses with a ready handshake.

Parameters:
WAIT_LIMIT, 16, max cycles a memory access may wait on mem_ready before mem_timeout sets; 0 disables the check
WAIT_W, 5, width of the wait counter; must hold WAIT_LIMIT

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
opcode  in  6  IR[31:26]
funct  in  6  IR[5:0]
mem_ready  in  1  memory completes the current read/write this cycle
pc_write  out  1  unconditional PC load
pc_write_cond  out  1  PC load if branch condition true
branch_ne  out  1  branch condition is zero==0 (BNE) instead of zero==1 (BEQ)
iord  out  1  memory address select: 0=PC, 1=ALUOut
mem_read  out  1  memory read request
mem_write  out  1  memory write request
ir_write  out  1  IR load
reg_dst  out  1  write register: 0=rt, 1=rd
mem_to_reg  out  1  writeback source: 1=MDR, 0=ALUOut
reg_write  out  1  register file write
alu_src_a  out  1  0=PC, 1=A
alu_src_b  out  2  00=B, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2
alu_op  out  2  00=add, 01=sub, 10=R-type (use funct)
pc_source  out  2  00=ALU result, 01=ALUOut, 10=jump target, 11=register A (JR)
illegal_op  out  1  unrecognised opcode seen in DECODE
instr_retired  out  1  one-cycle pulse when an instruction completes
mem_timeout  out  1  sticky: a wait exceeded WAIT_LIMIT

Behaviour:
- Reset: state<=FETCH, wait counter<=0, mem_timeout<=0. While reset is high, every output is forced to 0 in the same cycle, so no writes occur during reset. Reset mid-instruction aborts it; the first cycle after reset is FETCH.
- Outputs are Moore-decoded from state. The only exceptions are ir_write/pc_write in FETCH, which are qualified by mem_ready. Any signal not listed for a state is 0.
- FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00. Stay in FETCH while mem_ready=0. On mem_ready=1: ir_write=1, pc_write=1, go to DECODE.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00. Next state by opcode:
  - 100011/101011 -> MEM_ADDR
  - 000000 with funct 001000 -> JR
  - 000000 otherwise -> EXECUTE
  - 000100/000101 -> BRANCH
  - 001000 -> ADDI_EX
  - 000010 -> JUMP
  - anything else -> illegal_op=1 this cycle, next state FETCH, no retire pulse.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00. Go to MEM_READ if opcode=100011, else MEM_WRITE.
- MEM_READ: mem_read=1, iord=1. Wait for mem_ready, then go to MEM_WB.
- MEM_WB: reg_dst=0, mem_to_reg=1, reg_write=1, retire, go to FETCH.
- MEM_WRITE: mem_write=1, iord=1. Wait for mem_ready; on mem_ready: retire, go to FETCH.
- EXECUTE: alu_src_a=1, alu_src_b=00, alu_op=10, go to R_WB.
- R_WB: reg_dst=1, reg_write=1, retire, go to FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01, branch_ne=(opcode==000101), retire, go to FETCH.
- ADDI_EX: alu_src_a=1, alu_src_b=10, alu_op=00, go to ADDI_WB.
- ADDI_WB: reg_dst=0, reg_write=1, retire, go to FETCH.
- JUMP: pc_write=1, pc_source=10, retire, go to FETCH.
- JR: pc_write=1, pc_source=11, retire, go to FETCH.
- instr_retired: asserted combinationally in the completing state, qualified by mem_ready for MEM_WRITE.
- Wait counter:
  - Clears on entry to any wait state (FETCH, MEM_READ, MEM_WRITE) and whenever mem_ready=1.
  - Increments each cycle in a wait state with mem_ready=0, saturating at all-ones.
  - mem_timeout sets when the counter reaches WAIT_LIMIT (WAIT_LIMIT>0). It stays set until reset; the FSM keeps waiting.
- Latencies with mem_ready always 1: R/ADDI 4 cycles, LW 5, SW 4, BEQ/BNE/J/JR 3.

Decomposition:
- Shared package mc_pkg holds:
  - 4-bit state enum
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_J) and FN_JR
  - ALU_OP_ADD/SUB/RTYPE
  - ALUB_* and PCSRC_* select constants
- No sub-module: a single FSM file with separate next-state, output-decode and wait-counter processes.

Test Plan:
- Reset held 2 cycles with mem_ready=1 -> all outputs 0 during reset; next cycle state FETCH with mem_read=1, ir_write=1, pc_write=1.
- R-type ADD (opcode 000000, funct 100000), mem_ready=1 -> FETCH, DECODE, EXECUTE (alu_op=10, alu_src_a=1, alu_src_b=00), R_WB (reg_write=1, reg_dst=1, instr_retired=1); 4 cycles.
- LW with mem_ready low 2 cycles in MEM_READ -> mem_read=1, iord=1 for 3 cycles, then MEM_WB with mem_to_reg=1, reg_write=1; 7 cycles total.
- BNE (000101) -> BRANCH cycle shows alu_op=01, pc_write_cond=1, branch_ne=1, pc_source=01; BEQ gives branch_ne=0.
- Opcode 111111 -> illegal_op=1 in DECODE, no retire, FETCH next; JR (000000/001000) -> pc_write=1, pc_source=11.
- WAIT_LIMIT=4, mem_ready low 6 cycles in FETCH -> mem_timeout rises after 4 wait cycles and holds. Reset asserted during MEM_WRITE -> mem_write=0 that cycle, FETCH next, mem_timeout cleared.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle MIPS main control FSM:
// state enum, opcode/funct constants and datapath select values.
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXECUTE   = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_ADDI_EX   = 4'd9,
        S_ADDI_WB   = 4'd10,
        S_JUMP      = 4'd11,
        S_JR        = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] FN_JR    = 6'b001000;

    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_RTYPE = 2'b10;

    localparam logic [1:0] ALUB_REG    = 2'b00;
    localparam logic [1:0] ALUB_FOUR   = 2'b01;
    localparam logic [1:0] ALUB_IMM    = 2'b10;
    localparam logic [1:0] ALUB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;
    localparam logic [1:0] PCSRC_REG    = 2'b11;

    // States that stall on the memory ready handshake.
    function automatic logic is_wait_state(input state_t s);
        return (s == S_FETCH) || (s == S_MEM_READ) || (s == S_MEM_WRITE);
    endfunction

endpackage

// File: rtl/mc_control.sv
// Main control FSM for the multi-cycle MIPS datapath: sequences each
// instruction and drives every datapath enable and mux select.
module mc_control
    import mc_pkg::*;
#(
    parameter int unsigned WAIT_LIMIT = 16,
    parameter int unsigned WAIT_W     = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       branch_ne,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic       illegal_op,
    output logic       instr_retired,
    output logic       mem_timeout
);

    localparam logic [WAIT_W-1:0] LIMIT = WAIT_LIMIT[WAIT_W-1:0];

    state_t            state, next_state;
    logic [WAIT_W-1:0] wait_cnt, wait_cnt_nxt;
    logic              timeout_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_FETCH;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_FETCH:     if (mem_ready) next_state = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW:   next_state = S_MEM_ADDR;
                    OP_RTYPE: begin
                        if (funct == FN_JR) next_state = S_JR;
                        else                next_state = S_EXECUTE;
                    end
                    OP_BEQ, OP_BNE: next_state = S_BRANCH;
                    OP_ADDI:        next_state = S_ADDI_EX;
                    OP_J:           next_state = S_JUMP;
                    default:        next_state = S_FETCH;
                endcase
            end
            S_MEM_ADDR: begin
                if (opcode == OP_LW) next_state = S_MEM_READ;
                else                 next_state = S_MEM_WRITE;
            end
            S_MEM_READ:  if (mem_ready) next_state = S_MEM_WB;
            S_MEM_WRITE: if (mem_ready) next_state = S_FETCH;
            S_EXECUTE:   next_state = S_R_WB;
            S_ADDI_EX:   next_state = S_ADDI_WB;
            S_MEM_WB, S_R_WB, S_BRANCH, S_ADDI_WB, S_JUMP, S_JR:
                         next_state = S_FETCH;
            default:     next_state = S_FETCH;
        endcase
    end

    // Moore decode; reset masks every output so nothing is written while held.
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        branch_ne     = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = ALUB_REG;
        alu_op        = ALU_OP_ADD;
        pc_source     = PCSRC_ALU;
        illegal_op    = 1'b0;
        instr_retired = 1'b0;
        if (!reset) begin
            case (state)
                S_FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = ALUB_FOUR;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                end
                S_DECODE: begin
                    alu_src_b = ALUB_IMM_SH;
                    case (opcode)
                        OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_BNE, OP_ADDI, OP_J:
                                 illegal_op = 1'b0;
                        default: illegal_op = 1'b1;
                    endcase
                end
                S_MEM_ADDR, S_ADDI_EX: begin
                    alu_src_a = 1'b1;
                    alu_src_b = ALUB_IMM;
                end
                S_MEM_READ: begin
                    mem_read = 1'b1;
                    iord     = 1'b1;
                end
                S_MEM_WB: begin
                    mem_to_reg    = 1'b1;
                    reg_write     = 1'b1;
                    instr_retired = 1'b1;
                end
                S_MEM_WRITE: begin
                    mem_write     = 1'b1;
                    iord          = 1'b1;
                    instr_retired = mem_ready;
                end
                S_EXECUTE: begin
                    alu_src_a = 1'b1;
                    alu_op    = ALU_OP_RTYPE;
                end
                S_R_WB: begin
                    reg_dst       = 1'b1;
                    reg_write     = 1'b1;
                    instr_retired = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a     = 1'b1;
                    alu_op        = ALU_OP_SUB;
                    pc_write_cond = 1'b1;
                    pc_source     = PCSRC_ALUOUT;
                    branch_ne     = (opcode == OP_BNE);
                    instr_retired = 1'b1;
                end
                S_ADDI_WB: begin
                    reg_write     = 1'b1;
                    instr_retired = 1'b1;
                end
                S_JUMP: begin
                    pc_write      = 1'b1;
                    pc_source     = PCSRC_JUMP;
                    instr_retired = 1'b1;
                end
                S_JR: begin
                    pc_write      = 1'b1;
                    pc_source     = PCSRC_REG;
                    instr_retired = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Entry into a wait state takes priority so each access starts from zero.
    always_comb begin
        wait_cnt_nxt = wait_cnt;
        if (is_wait_state(next_state) && (next_state != state)) begin
            wait_cnt_nxt = '0;
        end else if (is_wait_state(state)) begin
            if (mem_ready) begin
                wait_cnt_nxt = '0;
            end else if (wait_cnt != '1) begin
                wait_cnt_nxt = wait_cnt + 1'b1;
            end
        end
    end

    // Timeout is set from the next count so flag and counter reach the limit together.
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            wait_cnt <= wait_cnt_nxt;
            if ((WAIT_LIMIT != 0) && (wait_cnt_nxt == LIMIT)) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign mem_timeout = timeout_q & ~reset;

endmodule
